dtcm_port_arbiter: RTL and testbench

Two-master arbiter in front of the DTCM data port. It shares the single DTCM read/write interface between the CPU data path (m0, output side of `memory_arbiter`'s DTCM channel) and a DMA/debug requester (m1). Grants are round-robin, and each transfer is sequenced through a valid/ready handshake. A per-transfer timeout returns an error instead of hanging a master.

---
 rtl/dtcm_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dtcm_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtcm_port_arbiter.sv
// Round-robin arbiter sharing the DTCM data port between the CPU (m0)
// and a DMA/debug requester (m1), with a per-transfer timeout.
`timescale 1ns/1ps
module dtcm_port_arbiter #(
    parameter int IO_MAP_WIDTH = 32,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic [IO_MAP_WIDTH-1:0] m0_addr,
    input  logic [IO_MAP_WIDTH-1:0] m0_wdata,
    input  logic                    m0_rw,
    output logic [IO_MAP_WIDTH-1:0] m0_rdata,
    output logic                    m0_ready,
    output logic                    m0_err,
    input  logic                    m1_req,
    input  logic [IO_MAP_WIDTH-1:0] m1_addr,
    input  logic [IO_MAP_WIDTH-1:0] m1_wdata,
    input  logic                    m1_rw,
    output logic [IO_MAP_WIDTH-1:0] m1_rdata,
    output logic                    m1_ready,
    output logic                    m1_err,
    output logic                    dtcm_valid,
    output logic [IO_MAP_WIDTH-1:0] dtcm_addr,
    output logic [IO_MAP_WIDTH-1:0] dtcm_wdata,
    output logic                    dtcm_rw,
    input  logic [IO_MAP_WIDTH-1:0] dtcm_rdata,
    input  logic                    dtcm_ready
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_prio;
    logic                    r_owner;
    logic                    r_err;
    logic [CW-1:0]           r_wait_cnt;
    logic [IO_MAP_WIDTH-1:0] r_m0_rdata;
    logic [IO_MAP_WIDTH-1:0] r_m1_rdata;
    logic                    w_in_grant;
    logic                    w_sel;
    logic                    w_timeout;
    logic                    w_done;

    assign w_in_grant = (r_state == GRANT0) || (r_state == GRANT1);
    assign w_sel      = (r_state == GRANT1);
    assign w_timeout  = w_in_grant && !dtcm_ready &&
                        (r_wait_cnt == CW'(TIMEOUT - 1));
    assign w_done     = w_in_grant && (dtcm_ready || w_timeout);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: arbitrate in IDLE, wait for completion or timeout in GRANTx
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    w_next = r_prio ? GRANT1 : GRANT0;
                end else if (m0_req) begin
                    w_next = GRANT0;
                end else if (m1_req) begin
                    w_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (w_done) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // DTCM mux and completion outputs, all quiet outside their states
    always_comb begin
        dtcm_valid = 1'b0;
        dtcm_addr  = '0;
        dtcm_wdata = '0;
        dtcm_rw    = 1'b0;
        m0_ready   = 1'b0;
        m0_err     = 1'b0;
        m1_ready   = 1'b0;
        m1_err     = 1'b0;
        if (w_in_grant) begin
            dtcm_valid = 1'b1;
            dtcm_addr  = w_sel ? m1_addr  : m0_addr;
            dtcm_wdata = w_sel ? m1_wdata : m0_wdata;
            dtcm_rw    = w_sel ? m1_rw    : m0_rw;
        end
        if (r_state == RESP) begin
            m0_ready = !r_owner;
            m0_err   = !r_owner && r_err;
            m1_ready = r_owner;
            m1_err   = r_owner && r_err;
        end
    end

    // Wait counter: zero outside a grant, counts stalled grant cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!w_in_grant) begin
            r_wait_cnt <= '0;
        end else if (!w_done) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    // Remember the granted master and whether its transfer timed out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_in_grant) begin
            r_owner <= w_sel;
            if (w_done) begin
                r_err <= w_timeout;
            end
        end
    end

    // Hand priority to the master that was not just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (r_state == RESP) begin
            r_prio <= !r_owner;
        end
    end

    // Master 0 read data: capture on read completion, zero on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rdata <= '0;
        end else if (r_state == GRANT0) begin
            if (dtcm_ready) begin
                if (!m0_rw) begin
                    r_m0_rdata <= dtcm_rdata;
                end
            end else if (w_timeout) begin
                r_m0_rdata <= '0;
            end
        end
    end

    // Master 1 read data: capture on read completion, zero on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m1_rdata <= '0;
        end else if (r_state == GRANT1) begin
            if (dtcm_ready) begin
                if (!m1_rw) begin
                    r_m1_rdata <= dtcm_rdata;
                end
            end else if (w_timeout) begin
                r_m1_rdata <= '0;
            end
        end
    end

    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Scoreboard bench for dtcm_port_arbiter: expected grants and responses
// are queued when a round is issued and popped by independent monitors.
`timescale 1ns/1ps
module tb_dtcm_port_arbiter;

    localparam int W     = 32;
    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    typedef struct {
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic         rw;
        int           lat;
    } xfer_t;

    typedef struct {
        int    m;
        xfer_t x;
    } gnt_t;

    typedef struct {
        logic [W-1:0] rdata;
        logic         err;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req   [2];
    logic [W-1:0] addr  [2];
    logic [W-1:0] wdata [2];
    logic         rw    [2];
    logic [W-1:0] rdata [2];
    logic         rdy   [2];
    logic         err   [2];
    logic         dv;
    logic [W-1:0] da;
    logic [W-1:0] dw;
    logic         drw;
    logic [W-1:0] drd;
    logic         drdy;

    xfer_t stim0 [$];
    xfer_t stim1 [$];
    gnt_t  exp_g [$];
    rsp_t  exp_r0 [$];
    rsp_t  exp_r1 [$];

    int           mprio;
    logic [W-1:0] shadow [2];
    int           n_chk;
    int           n_pass;

    dtcm_port_arbiter #(.IO_MAP_WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (req[0]),
        .m0_addr    (addr[0]),
        .m0_wdata   (wdata[0]),
        .m0_rw      (rw[0]),
        .m0_rdata   (rdata[0]),
        .m0_ready   (rdy[0]),
        .m0_err     (err[0]),
        .m1_req     (req[1]),
        .m1_addr    (addr[1]),
        .m1_wdata   (wdata[1]),
        .m1_rw      (rw[1]),
        .m1_rdata   (rdata[1]),
        .m1_ready   (rdy[1]),
        .m1_err     (err[1]),
        .dtcm_valid (dv),
        .dtcm_addr  (da),
        .dtcm_wdata (dw),
        .dtcm_rw    (drw),
        .dtcm_rdata (drd),
        .dtcm_ready (drdy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] data_of(input logic [W-1:0] a);
        if (a == 32'h0000_0FFC) return 32'hAABB_CCDD;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic xfer_t mk(input logic [W-1:0] a, input logic [W-1:0] d,
                                 input logic w, input int l);
        xfer_t t;
        t.addr  = a;
        t.wdata = d;
        t.rw    = w;
        t.lat   = l;
        return t;
    endfunction

    function automatic xfer_t rnd_xfer();
        int r;
        int l;
        r = $urandom_range(0, 19);
        if (r < 12)      l = r % 4;
        else if (r < 16) l = 13 + (r - 12);
        else             l = NEVER;
        return mk($urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)), l);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // DTCM responder and transfer monitor
    int           vcnt;
    logic [W-1:0] ca;
    logic [W-1:0] cw;
    logic         crw;
    bit           stable;

    initial forever begin
        @(posedge rst);
        vcnt = 0;
    end

    initial begin
        vcnt = 0;
        drdy = 1'b0;
        drd  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                vcnt = 0;
                drdy = 1'b0;
            end else if (dv) begin
                int lat;
                lat = (exp_g.size() > 0) ? exp_g[0].x.lat : NEVER;
                if (vcnt == 0) begin
                    ca = da; cw = dw; crw = drw; stable = 1'b1;
                end else if (da !== ca || dw !== cw || drw !== crw) begin
                    stable = 1'b0;
                end
                drdy = (vcnt == lat);
                drd  = drdy ? data_of(da) : $urandom;
                vcnt++;
            end else begin
                if (vcnt != 0) begin
                    gnt_t g;
                    int   ecyc;
                    if (exp_g.size() == 0) begin
                        chk("unexpected_xfer", ca, '1);
                    end else begin
                        g = exp_g.pop_front();
                        ecyc = (g.x.lat >= TMO) ? TMO : g.x.lat + 1;
                        chk("xfer_addr", ca, g.x.addr);
                        chk("xfer_rw", W'(crw), W'(g.x.rw));
                        chk("xfer_wdata", cw, g.x.wdata);
                        chk("valid_cycles", W'(vcnt), W'(ecyc));
                        chk("xfer_stable", W'(stable), 1);
                        chk("ready_after_xfer", W'(rdy[g.m]), 1);
                    end
                end
                vcnt = 0;
                drdy = 1'($urandom_range(0, 1));
                drd  = $urandom;
            end
        end
    end

    // Response monitor
    initial forever begin
        @(negedge clk);
        for (int x = 0; x < 2; x++) begin
            if (rdy[x]) begin
                rsp_t r;
                if ((x == 0 ? exp_r0.size() : exp_r1.size()) == 0) begin
                    chk("unexpected_ready", W'(x), '1);
                end else begin
                    r = (x == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
                    chk(x == 0 ? "m0_rdata" : "m1_rdata", rdata[x], r.rdata);
                    chk(x == 0 ? "m0_err" : "m1_err", W'(err[x]), W'(r.err));
                end
            end
        end
    end

    task automatic drive(input int x, input int skew);
        int    n;
        int    cnt;
        xfer_t t;
        n = (x == 0) ? stim0.size() : stim1.size();
        if (n > 0 && skew > 0) begin
            repeat (skew) @(posedge clk);
            #1;
        end
        for (int i = 0; i < n; i++) begin
            t = (x == 0) ? stim0[i] : stim1[i];
            req[x]   = 1'b1;
            addr[x]  = t.addr;
            wdata[x] = t.wdata;
            rw[x]    = t.rw;
            cnt = 0;
            @(negedge clk);
            while (!rdy[x] && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            if (!rdy[x]) chk("ready_wait", W'(cnt), 0);
            @(posedge clk);
            #1;
        end
        req[x] = 1'b0;
    endtask

    // Reference model: when both wait, the master not served last goes next
    task automatic run_round(input int skew);
        int    i0;
        int    i1;
        int    cur;
        int    tot;
        xfer_t t;
        rsp_t  r;
        gnt_t  g;
        i0  = 0;
        i1  = 0;
        tot = stim0.size() + stim1.size();
        if (stim0.size() > 0 && stim1.size() > 0 && skew == 0) cur = mprio;
        else cur = (stim0.size() > 0) ? 0 : 1;
        for (int k = 0; k < tot; k++) begin
            if (cur == 0 && i0 >= stim0.size()) cur = 1;
            if (cur == 1 && i1 >= stim1.size()) cur = 0;
            if (cur == 0) begin t = stim0[i0]; i0++; end
            else begin t = stim1[i1]; i1++; end
            g.m = cur;
            g.x = t;
            exp_g.push_back(g);
            r.err   = (t.lat >= TMO);
            r.rdata = r.err ? '0 : (t.rw ? shadow[cur] : data_of(t.addr));
            shadow[cur] = r.rdata;
            if (cur == 0) exp_r0.push_back(r);
            else exp_r1.push_back(r);
            mprio = 1 - cur;
            cur   = 1 - cur;
        end
        @(posedge clk);
        #1;
        fork
            drive(0, 0);
            drive(1, skew);
        join
        repeat (2) @(posedge clk);
        #1;
        stim0.delete();
        stim1.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        mprio     = 0;
        shadow[0] = '0;
        shadow[1] = '0;
    endtask

    initial begin
        int n0;
        int n1;
        int mask;
        int skew;
        n_chk  = 0;
        n_pass = 0;
        for (int x = 0; x < 2; x++) begin
            req[x] = 1'b0; addr[x] = '0; wdata[x] = '0; rw[x] = 1'b0;
        end
        do_reset();

        @(negedge clk);
        chk("rst_dtcm_valid", W'(dv), 0);
        chk("rst_dtcm_addr", da, 0);
        chk("rst_dtcm_wdata", dw, 0);
        chk("rst_dtcm_rw", W'(drw), 0);
        chk("rst_m0_ready", W'(rdy[0]), 0);
        chk("rst_m1_ready", W'(rdy[1]), 0);
        chk("rst_m0_err", W'(err[0]), 0);
        chk("rst_m1_err", W'(err[1]), 0);
        chk("rst_m0_rdata", rdata[0], 0);
        chk("rst_m1_rdata", rdata[1], 0);

        stim0.push_back(mk(32'h0000_0FFC, 32'h0, 1'b0, 0));
        run_round(0);

        do_reset();
        stim0.push_back(mk(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 0));
        stim1.push_back(mk(32'h0000_0010, 32'h5555_AAAA, 1'b0, 0));
        run_round(0);

        for (int i = 0; i < 3; i++) begin
            stim0.push_back(mk(32'h1000 + 32'(i * 4), $urandom, 1'b0, $urandom_range(0, 3)));
            stim1.push_back(mk(32'h2000 + 32'(i * 4), $urandom, 1'b1, $urandom_range(0, 3)));
        end
        run_round(0);

        stim1.push_back(mk(32'h0000_0200, 32'h1234_5678, 1'b1, 3));
        run_round(0);

        stim0.push_back(mk(32'h0000_0400, 32'h0, 1'b0, NEVER));
        run_round(0);
        stim1.push_back(mk(32'h0000_0500, 32'h0, 1'b0, 1));
        run_round(0);

        stim0.push_back(mk(32'h0000_0600, 32'h0, 1'b0, 15));
        stim1.push_back(mk(32'h0000_0700, 32'h0, 1'b0, 16));
        run_round(0);

        @(posedge clk);
        #1;
        req[1]   = 1'b1;
        addr[1]  = 32'h0000_0300;
        wdata[1] = 32'hCAFE_F00D;
        rw[1]    = 1'b0;
        repeat (4) @(negedge clk);
        chk("grant1_valid", W'(dv), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_dtcm_valid", W'(dv), 0);
        chk("midrst_dtcm_addr", da, 0);
        chk("midrst_m1_ready", W'(rdy[1]), 0);
        chk("midrst_m1_rdata", rdata[1], 0);
        chk("midrst_m0_rdata", rdata[0], 0);
        req[1] = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mprio     = 0;
        shadow[0] = '0;
        shadow[1] = '0;
        stim0.push_back(mk(32'h0000_0800, 32'h0, 1'b0, 0));
        stim1.push_back(mk(32'h0000_0900, 32'h0, 1'b0, 0));
        run_round(0);

        for (int rd = 0; rd < 40; rd++) begin
            mask = $urandom_range(1, 3);
            skew = 0;
            if (mask == 3 && $urandom_range(0, 3) == 0) skew = $urandom_range(1, 4);
            n0 = (mask & 1) ? ((skew > 0) ? 1 : $urandom_range(1, 3)) : 0;
            n1 = (mask & 2) ? $urandom_range(1, 3) : 0;
            for (int i = 0; i < n0; i++) stim0.push_back(rnd_xfer());
            for (int i = 0; i < n1; i++) stim1.push_back(rnd_xfer());
            run_round(skew);
        end

        repeat (4) @(posedge clk);
        chk("pending_grants", W'(exp_g.size()), 0);
        chk("pending_m0_rsp", W'(exp_r0.size()), 0);
        chk("pending_m1_rsp", W'(exp_r1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
